// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// FSM state encoding and a constant-time clog2.
package rr_mux_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    function automatic int max1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Rotating first-one finder: first set req bit at or after ptr,
// wrapping N-1 -> 0. Purely combinational.
module rr_pick
    import rr_mux_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    function automatic logic [SEL_W-1:0] wrap_idx(
        input logic [SEL_W-1:0] p,
        input int               i
    );
        int s;
        s = int'(p) + i;
        if (s >= N) s = s - N;
        return SEL_W'(s);
    endfunction

    // scan from ptr upward, keep the first hit
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[wrap_idx(ptr, i)]) begin
                any = 1'b1;
                idx = wrap_idx(ptr, i);
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter and sequencer for the shared select datapath.
// Holds a grant until last beat or idle timeout, forwards the stream.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter  int N       = 4,
    parameter  int W       = 8,
    parameter  int TIMEOUT = 16,
    localparam int SEL_W   = clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_last,
    output logic [N-1:0]     in_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             timeout_p
);

    localparam int CNT_W = max1(clog2(TIMEOUT + 1));
    localparam logic [CNT_W-1:0] TO_LAST =
        (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_t           st_q;
    state_t           st_nx;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_nx;
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_nx;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nx;
    logic             tp_q;
    logic             tp_nx;

    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;

    logic             busy_w;
    logic             cur_req;
    logic             cur_last;
    logic             xfer;
    logic             done_last;
    logic             to_hit;

    rr_pick #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_pick (
        .req (req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    function automatic logic [SEL_W-1:0] next_ptr(
        input logic [SEL_W-1:0] s
    );
        if (s == SEL_W'(N - 1)) return '0;
        return s + SEL_W'(1);
    endfunction

    assign busy_w    = (st_q == ST_BUSY);
    assign cur_req   = req[sel_q];
    assign cur_last  = in_last[sel_q];
    assign xfer      = busy_w & cur_req & out_ready;
    assign done_last = xfer & cur_last;
    // count reaches TIMEOUT on this idle cycle
    assign to_hit    = (TIMEOUT != 0) && busy_w &&
                       !cur_req && (cnt_q == TO_LAST);

    // state, grant, pointer, idle counter and pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= ST_IDLE;
            sel_q <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
            tp_q  <= 1'b0;
        end else begin
            st_q  <= st_nx;
            sel_q <= sel_nx;
            ptr_q <= ptr_nx;
            cnt_q <= cnt_nx;
            tp_q  <= tp_nx;
        end
    end

    // next-state: arbitrate in IDLE, release on last or timeout in BUSY
    always_comb begin
        st_nx  = st_q;
        sel_nx = sel_q;
        ptr_nx = ptr_q;
        cnt_nx = cnt_q;
        tp_nx  = 1'b0;
        unique case (st_q)
            ST_IDLE: begin
                cnt_nx = '0;
                if (pick_any) begin
                    st_nx  = ST_BUSY;
                    sel_nx = pick_idx;
                end
            end
            ST_BUSY: begin
                if (done_last) begin
                    st_nx  = ST_IDLE;
                    ptr_nx = next_ptr(sel_q);
                    cnt_nx = '0;
                end else if (to_hit) begin
                    st_nx  = ST_IDLE;
                    ptr_nx = next_ptr(sel_q);
                    cnt_nx = '0;
                    tp_nx  = 1'b1;
                end else if (cur_req) begin
                    cnt_nx = '0;
                end else if (TIMEOUT != 0) begin
                    cnt_nx = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                st_nx = ST_IDLE;
            end
        endcase
    end

    // N:1 data select driven by the registered grant only
    always_comb begin
        out_data = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_q == SEL_W'(i)) out_data = in_data[i*W +: W];
        end
    end

    // accept goes only to the granted requester
    always_comb begin
        in_ready        = '0;
        in_ready[sel_q] = busy_w & out_ready;
    end

    assign out_valid = busy_w & cur_req;
    assign out_last  = cur_last;
    assign sel       = sel_q;
    assign busy      = busy_w;
    assign timeout_p = tp_q;

endmodule
